fpu_share_ctrl: RTL and testbench
=================================

# fpu_share_ctrl

Round-robin controller that time-shares a single FPU core among `NREQ` requesters. It accepts one operation at a time over a valid/ready handshake and drives the FPU operand and mode inputs with registered values. After the fixed FPU pipeline latency it samples the result and exception flags and returns them to the granting requester as a one-cycle response pulse. It sits between the FPU core (the `fpu_intf` signal set) and client blocks.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `FPU_LAT`, 4, cycles from FPU operand change to valid `out`/flags (≥1)

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  NREQ  request per requester
- `req_ready`  out  NREQ  accept strobe, one-hot or zero
- `req_op`  in  3*NREQ  fpu_op per requester, slice i = [3i+2:3i]
- `req_rmode`  in  2*NREQ  rounding mode per requester
- `req_opa`, `req_opb`  in  32*NREQ  operands per requester
- `rsp_valid`  out  NREQ  one-cycle response pulse, one-hot or zero
- `rsp_out`  out  32  result, shared by all requesters
- `rsp_flags`  out  8  {inf,snan,qnan,ine,overflow,underflow,zero,div_by_zero}, bit 7..0
- `busy`  out  1  high whenever state ≠ IDLE
- `fpu_op`, `fpu_rmode`, `fpu_opa`, `fpu_opb`  out  3/2/32/32  registered drive to FPU
- `fpu_out`  in  32  FPU result
- `fpu_flags`  in  8  FPU flags, same order as `rsp_flags`
- `flag_clr`  in  NREQ  sticky clear (feature-dependent, see Configuration)
- `sticky_flags`  out  8*NREQ  per-requester sticky flags (feature-dependent)

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: the grant is computed combinationally from `req_valid` and round-robin pointer `ptr`. Search order is ptr, ptr+1, …, wrapping mod NREQ. `req_ready[g]=1` only in IDLE and only for the granted g.
- On handshake (valid & ready at an edge):
  - latch slice g into `fpu_*`, store g;
  - `ptr <= (g+1) mod NREQ`;
  - load counter with FPU_LAT and go to WAIT.
- WAIT: decrement the counter each cycle. On the edge where the counter reads 1, capture `fpu_out`/`fpu_flags` into `rsp_out`/`rsp_flags` and go to RESP.
- RESP: `rsp_valid[g]=1` for exactly one cycle, then go to IDLE. `rsp_out`/`rsp_flags` hold until the next capture.
- Responses have no backpressure; the requester must take the pulse.
- Requesters hold payload stable while valid and must not drop valid before ready. Valid may stay high after a response to issue the next operation.
- `fpu_*` hold their values after the response until the next accept.
- Non-granted requests wait. Round-robin guarantees each waits at most NREQ-1 operations.

## Timing
- Accept at edge T. `fpu_*` change after T. Result is captured at edge T+FPU_LAT. `rsp_valid` is high in cycle T+FPU_LAT to T+FPU_LAT+1.
- Earliest next accept is edge T+FPU_LAT+2. Throughput is 1 op per FPU_LAT+2 cycles.
- Reset values: state IDLE, ptr 0, counter 0, all outputs 0 (`req_ready`, `rsp_valid`, `rsp_out`, `rsp_flags`, `busy`, `fpu_*`, `sticky_flags`).
- Reset asserted mid-operation aborts the operation. No response is issued and the result is discarded.
- First grant after reset goes to the lowest-index valid requester.

## Configuration
- `FPU_SHARE_STICKY_EN` defined:
  - in the RESP cycle, `sticky_flags[8g+7:8g] |= rsp_flags`;
  - `flag_clr[i]` zeroes slice i at the next edge;
  - if a clear and a set hit the same slice in the same cycle, set wins.
- Not defined: `sticky_flags` is tied to 0, `flag_clr` is ignored, and no sticky registers are synthesized.

## Test plan
- Single add, FPU_LAT=4: requester 1 sends op 000, rmode 00, opa 0x3F800000, opb 0x40000000. Expect ready[1] at T, `fpu_*` updated after T, rsp_valid[1] in cycle T+4, rsp_out 0x40400000, flags 0x00.
- Divide by zero: op 011, opa 0x3F800000, opb 0x00000000. Expect rsp_out 0x7F800000 and rsp_flags 0x81. With `FPU_SHARE_STICKY_EN`, sticky slice reads 0x81 until `flag_clr` is pulsed, then 0x00.
- All four requesters held valid from reset. Expect grant order 0,1,2,3,0, with accepts spaced FPU_LAT+2 cycles apart.
- Requesters 2 and 3 valid with ptr=3. Expect 3 granted first, then 2 next.
- Reset asserted in WAIT. Expect no rsp_valid, all outputs 0, and the first grant after release going to the lowest valid index.
- Same-cycle clear and set on one sticky slice (macro defined). Expect the new flags retained.

Source files
------------

// File: rtl/fpu_share_if.sv
// Signal bundle between fpu_share_ctrl, its client requesters and the shared FPU core.
// slave = controller side, master = clients + FPU side.
interface fpu_share_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0][2:0]   req_op;
    logic [NREQ-1:0][1:0]   req_rmode;
    logic [NREQ-1:0][31:0]  req_opa;
    logic [NREQ-1:0][31:0]  req_opb;
    logic [NREQ-1:0]        rsp_valid;
    logic [31:0]            rsp_out;
    logic [7:0]             rsp_flags;
    logic                   busy;
    logic [2:0]             fpu_op;
    logic [1:0]             fpu_rmode;
    logic [31:0]            fpu_opa;
    logic [31:0]            fpu_opb;
    logic [31:0]            fpu_out;
    logic [7:0]             fpu_flags;
    logic [NREQ-1:0]        flag_clr;
    logic [NREQ-1:0][7:0]   sticky_flags;

    modport slave (
        input  req_valid, req_op, req_rmode, req_opa, req_opb, fpu_out, fpu_flags, flag_clr,
        output req_ready, rsp_valid, rsp_out, rsp_flags, busy,
               fpu_op, fpu_rmode, fpu_opa, fpu_opb, sticky_flags
    );

    modport master (
        output req_valid, req_op, req_rmode, req_opa, req_opb, fpu_out, fpu_flags, flag_clr,
        input  req_ready, rsp_valid, rsp_out, rsp_flags, busy,
               fpu_op, fpu_rmode, fpu_opa, fpu_opb, sticky_flags
    );
endinterface

// File: rtl/fpu_share_ctrl.sv
// Round-robin time-sharing of one fixed-latency FPU among NREQ requesters.
// Optional per-requester sticky exception flags when FPU_SHARE_STICKY_EN is defined.
`ifdef FPU_SHARE_STICKY_EN
module fpu_share_sticky_lane (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set,
    input  logic [7:0] flags,
    input  logic       clr,
    output logic [7:0] sticky
);
    // set has priority so a flag raised in the clearing cycle is never lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   sticky <= '0;
        else if (set) sticky <= sticky | flags;
        else if (clr) sticky <= '0;
    end
endmodule
`endif

module fpu_share_ctrl #(
    parameter int NREQ    = 4,
    parameter int FPU_LAT = 4
) (
    input logic          clk,
    input logic          rst_n,
    fpu_share_if.slave   bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(FPU_LAT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] ptr, gnt, gnt_q;
    logic          gnt_vld, accept;
    logic [CW-1:0] cnt;
    logic [2:0]    fpu_op_q;
    logic [1:0]    fpu_rmode_q;
    logic [31:0]   fpu_opa_q, fpu_opb_q, rsp_out_q;
    logic [7:0]    rsp_flags_q;

    // Search ptr, ptr+1, ... wrapping; iterate backwards so the nearest one wins.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(ptr) + k) % NREQ]) begin
                gnt     = PW'((int'(ptr) + k) % NREQ);
                gnt_vld = 1'b1;
            end
        end
    end

    assign accept = (state == IDLE) && gnt_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = WAIT;
            WAIT: if (cnt <= CW'(1)) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            gnt_q       <= '0;
            cnt         <= '0;
            fpu_op_q    <= '0;
            fpu_rmode_q <= '0;
            fpu_opa_q   <= '0;
            fpu_opb_q   <= '0;
            rsp_out_q   <= '0;
            rsp_flags_q <= '0;
        end else if (accept) begin
            fpu_op_q    <= bus.req_op[gnt];
            fpu_rmode_q <= bus.req_rmode[gnt];
            fpu_opa_q   <= bus.req_opa[gnt];
            fpu_opb_q   <= bus.req_opb[gnt];
            gnt_q       <= gnt;
            ptr         <= (int'(gnt) == NREQ - 1) ? '0 : gnt + PW'(1);
            cnt         <= CW'(FPU_LAT);
        end else if (state == WAIT) begin
            cnt <= cnt - CW'(1);
            if (cnt <= CW'(1)) begin
                rsp_out_q   <= bus.fpu_out;
                rsp_flags_q <= bus.fpu_flags;
            end
        end
    end

    // rst_n gate keeps req_ready low while reset is held with requests pending.
    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign bus.req_ready[i] = rst_n && accept && (gnt == PW'(i));
        assign bus.rsp_valid[i] = (state == RESP) && (gnt_q == PW'(i));
    end

    assign bus.busy      = (state != IDLE);
    assign bus.fpu_op    = fpu_op_q;
    assign bus.fpu_rmode = fpu_rmode_q;
    assign bus.fpu_opa   = fpu_opa_q;
    assign bus.fpu_opb   = fpu_opb_q;
    assign bus.rsp_out   = rsp_out_q;
    assign bus.rsp_flags = rsp_flags_q;

`ifdef FPU_SHARE_STICKY_EN
    for (genvar i = 0; i < NREQ; i++) begin : g_sticky
        fpu_share_sticky_lane u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .set    (bus.rsp_valid[i]),
            .flags  (rsp_flags_q),
            .clr    (bus.flag_clr[i]),
            .sticky (bus.sticky_flags[i])
        );
    end
`else
    logic unused_flag_clr;
    assign unused_flag_clr  = ^bus.flag_clr;
    assign bus.sticky_flags = '0;
`endif
endmodule

// File: tb/tb_fpu_share_ctrl.sv
// Scoreboard bench for fpu_share_ctrl with a pipelined behavioural FPU stand-in.
module tb_fpu_share_ctrl;
    localparam int NREQ = 4;
    localparam int LAT  = 4;
    localparam int D    = LAT - 1;

    typedef struct {
        int          idx;
        logic [31:0] out;
        logic [7:0]  flags;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpu_share_if #(.NREQ(NREQ)) bus ();

    fpu_share_ctrl #(.NREQ(NREQ), .FPU_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_chk = 0, n_pass = 0;
    int cyc = 0, acc_cnt = 0, rsp_cnt = 0, last_acc = 0;
    exp_t exp_q[$];
    int   acc_i[$], acc_t[$];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // FPU stand-in: D register stages, so a result is first visible LAT edges after operands change.
    function automatic logic [39:0] fpu_model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        if (op == 3'b000 && a == 32'h3F800000 && b == 32'h40000000) return {8'h00, 32'h40400000};
        if (op == 3'b011 && b == 32'h0) return {8'h81, 32'h7F800000};
        return {a[7:0] ^ b[7:0], a ^ b};
    endfunction

    logic [39:0] pipe [D];
    always @(posedge clk) begin
        pipe[0] <= fpu_model(bus.fpu_op, bus.fpu_opa, bus.fpu_opb);
        for (int k = 1; k < D; k++) pipe[k] <= pipe[k-1];
    end
    assign {bus.fpu_flags, bus.fpu_out} = pipe[D-1];

    always @(posedge clk) cyc <= cyc + 1;

    // accept watcher: ready seen here means handshake on the coming edge
    always @(negedge clk) begin
        if (rst_n && (bus.req_ready & bus.req_valid) != 0) begin
            for (int k = 0; k < NREQ; k++)
                if (bus.req_ready[k]) acc_i.push_back(k);
            acc_t.push_back(cyc + 1);
            last_acc = cyc + 1;
            acc_cnt++;
        end
    end

    // response monitor
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid != 0) begin
            exp_t e;
            rsp_cnt++;
            chk("rsp_latency", 64'(cyc - last_acc), 64'(LAT));
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL rsp_unexpected: rsp_valid 0x%0h with nothing expected", bus.rsp_valid);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_idx",   64'(bus.rsp_valid), 64'(1) << e.idx);
                chk("rsp_out",   64'(bus.rsp_out),   64'(e.out));
                chk("rsp_flags", 64'(bus.rsp_flags), 64'(e.flags));
            end
        end
    end

    task automatic push(int idx, logic [31:0] out, logic [7:0] flags);
        exp_t e;
        e.idx = idx; e.out = out; e.flags = flags;
        exp_q.push_back(e);
    endtask

    // waits until acc_cnt reaches n, then through the handshake edge
    task automatic wait_acc(int n);
        int t = 0;
        while (acc_cnt < n && t < 400) begin @(negedge clk); t++; end
        chk("accept_timeout", 64'(acc_cnt >= n), 64'(1));
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp(int n);
        int t = 0;
        while (rsp_cnt < n && t < 400) begin @(negedge clk); t++; end
        chk("rsp_timeout", 64'(rsp_cnt >= n), 64'(1));
        @(posedge clk); #1;
    endtask

    task automatic set_req(int i, logic [2:0] op, logic [1:0] rm, logic [31:0] a, logic [31:0] b);
        bus.req_op[i] = op; bus.req_rmode[i] = rm; bus.req_opa[i] = a; bus.req_opb[i] = b;
    endtask

    task automatic issue(int i, logic [2:0] op, logic [1:0] rm, logic [31:0] a, logic [31:0] b);
        set_req(i, op, rm, a, b);
        bus.req_valid[i] = 1'b1;
        wait_acc(acc_cnt + 1);
        bus.req_valid[i] = 1'b0;
    endtask

    initial begin
        int a0, r0;
        bus.req_valid = '0; bus.req_op = '0; bus.req_rmode = '0;
        bus.req_opa = '0; bus.req_opb = '0; bus.flag_clr = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 0);
        chk("rst_rsp_out",   64'(bus.rsp_out), 0);
        chk("rst_rsp_flags", 64'(bus.rsp_flags), 0);
        chk("rst_busy",      64'(bus.busy), 0);
        chk("rst_fpu_drive", {bus.fpu_op, bus.fpu_rmode, bus.fpu_opa, bus.fpu_opb}, 0);
        chk("rst_sticky",    64'(bus.sticky_flags), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // single add on requester 1
        push(1, 32'h40400000, 8'h00);
        issue(1, 3'b000, 2'b00, 32'h3F800000, 32'h40000000);
        chk("add_fpu_opa", 64'(bus.fpu_opa), 64'h3F800000);
        chk("add_fpu_opb", 64'(bus.fpu_opb), 64'h40000000);
        chk("add_fpu_op",  64'(bus.fpu_op), 0);
        chk("add_busy",    64'(bus.busy), 1);
        wait_rsp(1);
        chk("add_fpu_hold", 64'(bus.fpu_opa), 64'h3F800000);

        // divide by zero on requester 2, then sticky clear
        push(2, 32'h7F800000, 8'h81);
        issue(2, 3'b011, 2'b00, 32'h3F800000, 32'h00000000);
        wait_rsp(2);
`ifdef FPU_SHARE_STICKY_EN
        chk("dbz_sticky_set", 64'(bus.sticky_flags[2]), 64'h81);
        repeat (2) @(posedge clk); #1;
        chk("dbz_sticky_hold", 64'(bus.sticky_flags[2]), 64'h81);
        bus.flag_clr[2] = 1'b1;
        @(posedge clk); #1 bus.flag_clr[2] = 1'b0;
        chk("dbz_sticky_clr", 64'(bus.sticky_flags[2]), 0);
`else
        chk("dbz_sticky_off", 64'(bus.sticky_flags), 0);
`endif

        // all four held valid from reset: order 0,1,2,3,0 spaced LAT+2
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 3'b001, 2'b00, {28'h1234567, 4'(i)}, 32'h000000F0);
        bus.req_valid = '1;
        repeat (2) @(negedge clk);
        chk("rr_rst_ready", 64'(bus.req_ready), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        a0 = acc_cnt; r0 = rsp_cnt;
        push(0, 32'h12345680, 8'h80); push(1, 32'h12345681, 8'h81);
        push(2, 32'h12345682, 8'h82); push(3, 32'h12345683, 8'h83);
        push(0, 32'h12345680, 8'h80);
        wait_acc(a0 + 5);
        bus.req_valid = '0;
        wait_rsp(r0 + 5);
        for (int k = 0; k < 5; k++) chk("rr_order", 64'(acc_i[a0 + k]), 64'(k % NREQ));
        for (int k = 1; k < 5; k++) chk("rr_spacing", 64'(acc_t[a0 + k] - acc_t[a0 + k - 1]), 64'(LAT + 2));

        // move ptr to 3, then 2 and 3 together: 3 first, then 2
        push(2, 32'h12345682, 8'h82);
        issue(2, 3'b001, 2'b00, 32'h12345672, 32'h000000F0);
        wait_rsp(rsp_cnt + 1);
        a0 = acc_cnt; r0 = rsp_cnt;
        push(3, 32'h12345683, 8'h83); push(2, 32'h12345682, 8'h82);
        bus.req_valid[2] = 1'b1; bus.req_valid[3] = 1'b1;
        wait_acc(a0 + 2);
        bus.req_valid = '0;
        wait_rsp(r0 + 2);
        chk("ptr3_first",  64'(acc_i[a0]), 3);
        chk("ptr3_second", 64'(acc_i[a0 + 1]), 2);

        // reset during WAIT aborts; first grant afterwards is the lowest valid index
        issue(1, 3'b001, 2'b00, 32'h12345671, 32'h000000F0);
        @(posedge clk); @(posedge clk); #1;
        r0 = rsp_cnt;
        rst_n = 1'b0;
        bus.req_valid[1] = 1'b1; bus.req_valid[3] = 1'b1;
        #1;
        chk("abort_busy",    64'(bus.busy), 0);
        chk("abort_rsp_out", 64'(bus.rsp_out), 0);
        chk("abort_fpu_opa", 64'(bus.fpu_opa), 0);
        chk("abort_ready",   64'(bus.req_ready), 0);
        repeat (6) @(posedge clk); #1;
        chk("abort_no_rsp", 64'(rsp_cnt), 64'(r0));
        a0 = acc_cnt;
        push(1, 32'h12345681, 8'h81);
        rst_n = 1'b1;
        wait_acc(a0 + 1);
        bus.req_valid = '0;
        chk("post_rst_grant", 64'(acc_i[a0]), 1);
        wait_rsp(r0 + 1);

        // same-cycle clear and set on slice 3: new flags survive
        push(3, 32'h0000004A, 8'h4A);
        issue(3, 3'b001, 2'b01, 32'h0000000A, 32'h00000040);
        wait_rsp(rsp_cnt + 1);
        push(3, 32'h00000035, 8'h35);
        bus.flag_clr[3] = 1'b1;
        issue(3, 3'b001, 2'b00, 32'h00000005, 32'h00000030);
        wait_rsp(rsp_cnt + 1);
        bus.flag_clr[3] = 1'b0;
`ifdef FPU_SHARE_STICKY_EN
        chk("clr_set_same", 64'(bus.sticky_flags[3]), 64'h35);
`else
        chk("sticky_tied0", 64'(bus.sticky_flags), 0);
`endif

        repeat (4) @(posedge clk); #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
